// File: rtl/tcam_mem_d1.sv
// Ternary CAM of SIZE value/mask/valid entries; write/clear acknowledged by done one cycle later.
// Search latency 2 cycles at one search per cycle; no backpressure, every request is accepted.
module tcam_mem_d1 #(
    parameter int WIDTH      = 32,
    parameter int SIZE       = 8,
    parameter int INDEX_SIZE = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    write_en,
    input  logic                    clear_en,
    input  logic [INDEX_SIZE-1:0]   index,
    input  logic [WIDTH-1:0]        write_data,
    input  logic [WIDTH-1:0]        write_mask,
    input  logic                    write_valid,
    output logic                    done,
    input  logic                    search_go,
    input  logic [WIDTH-1:0]        search_key,
    output logic                    search_done,
    output logic                    hit,
    output logic [INDEX_SIZE-1:0]   match_index,
    output logic [SIZE*WIDTH-1:0]   read_data,
    output logic [SIZE-1:0]         read_valid
);

    // Packed so that entry i lands at read_data[i*WIDTH +: WIDTH] directly.
    logic [SIZE-1:0][WIDTH-1:0] value_q, value_d;
    logic [SIZE-1:0][WIDTH-1:0] mask_q,  mask_d;
    logic [SIZE-1:0]            valid_q, valid_d;

    logic                       done_q, done_d;

    logic                       s1_vld_q, s1_vld_d;
    logic [SIZE-1:0]            s1_match_q, s1_match_d;
    logic [SIZE-1:0]            match_vec;

    logic                       search_done_q, search_done_d;
    logic                       hit_q, hit_d;
    logic [INDEX_SIZE-1:0]      match_index_q, match_index_d;
    logic [INDEX_SIZE-1:0]      enc_idx;

    // Entry update: clear wins over write; out-of-range index matches no entry.
    always_comb begin
        value_d = value_q;
        mask_d  = mask_q;
        valid_d = valid_q;
        done_d  = write_en | clear_en;
        if (clear_en) begin
            valid_d = '0;
        end else if (write_en) begin
            for (int i = 0; i < SIZE; i++) begin
                if (index == INDEX_SIZE'(i)) begin
                    value_d[i] = write_data;
                    mask_d[i]  = write_mask;
                    valid_d[i] = write_valid;
                end
            end
        end
    end

    // Stage 1 compares against pre-edge contents, so same-cycle writes are not seen.
    always_comb begin
        match_vec = '0;
        for (int i = 0; i < SIZE; i++) begin
            match_vec[i] = valid_q[i] && (((search_key ^ value_q[i]) & mask_q[i]) == '0);
        end
        s1_vld_d   = search_go;
        s1_match_d = search_go ? match_vec : '0;
    end

    // Stage 2: lowest-index priority encode; index stays 0 when nothing matched.
    always_comb begin
        enc_idx = '0;
        for (int i = SIZE - 1; i >= 0; i--) begin
            if (s1_match_q[i]) begin
                enc_idx = INDEX_SIZE'(i);
            end
        end
        search_done_d = s1_vld_q;
        hit_d         = s1_vld_q & (|s1_match_q);
        match_index_d = (s1_vld_q && (|s1_match_q)) ? enc_idx : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            value_q       <= '0;
            mask_q        <= '0;
            valid_q       <= '0;
            done_q        <= 1'b0;
            s1_vld_q      <= 1'b0;
            s1_match_q    <= '0;
            search_done_q <= 1'b0;
            hit_q         <= 1'b0;
            match_index_q <= '0;
        end else begin
            value_q       <= value_d;
            mask_q        <= mask_d;
            valid_q       <= valid_d;
            done_q        <= done_d;
            s1_vld_q      <= s1_vld_d;
            s1_match_q    <= s1_match_d;
            search_done_q <= search_done_d;
            hit_q         <= hit_d;
            match_index_q <= match_index_d;
        end
    end

    assign done        = done_q;
    assign search_done = search_done_q;
    assign hit         = hit_q;
    assign match_index = match_index_q;
    assign read_data   = value_q;
    assign read_valid  = valid_q;

endmodule

// File: tb/tb_tcam_mem_d1.sv
// Randomised and directed bench for tcam_mem_d1 against an array/queue reference model.
module tb_tcam_mem_d1;

    localparam int W  = 32;
    localparam int N  = 6;
    localparam int IW = 3;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            write_en = 1'b0;
    logic            clear_en = 1'b0;
    logic [IW-1:0]   index = '0;
    logic [W-1:0]    write_data = '0;
    logic [W-1:0]    write_mask = '0;
    logic            write_valid = 1'b0;
    logic            done;
    logic            search_go = 1'b0;
    logic [W-1:0]    search_key = '0;
    logic            search_done;
    logic            hit;
    logic [IW-1:0]   match_index;
    logic [N*W-1:0]  read_data;
    logic [N-1:0]    read_valid;

    tcam_mem_d1 #(.WIDTH(W), .SIZE(N), .INDEX_SIZE(IW)) dut (
        .clk         (clk),
        .reset       (reset),
        .write_en    (write_en),
        .clear_en    (clear_en),
        .index       (index),
        .write_data  (write_data),
        .write_mask  (write_mask),
        .write_valid (write_valid),
        .done        (done),
        .search_go   (search_go),
        .search_key  (search_key),
        .search_done (search_done),
        .hit         (hit),
        .match_index (match_index),
        .read_data   (read_data),
        .read_valid  (read_valid)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: entry arrays plus a queue of results owed to future cycles.
    typedef struct {
        bit vld;
        bit hit;
        int idx;
    } res_t;

    logic [W-1:0] mv [N];
    logic [W-1:0] mm [N];
    bit           mval [N];
    res_t         pq [$];
    bit           exp_done;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic res_t model_search(input bit go, input logic [W-1:0] key);
        res_t r;
        r.vld = go;
        r.hit = 1'b0;
        r.idx = 0;
        if (go) begin
            for (int i = 0; i < N; i++) begin
                if (!r.hit && mval[i] && (((key ^ mv[i]) & mm[i]) == 0)) begin
                    r.hit = 1'b1;
                    r.idx = i;
                end
            end
        end
        return r;
    endfunction

    task automatic model_clear_all();
        res_t e;
        e.vld = 0; e.hit = 0; e.idx = 0;
        for (int i = 0; i < N; i++) begin
            mv[i] = '0; mm[i] = '0; mval[i] = 0;
        end
        pq.delete();
        pq.push_back(e);
        pq.push_back(e);
        exp_done = 0;
    endtask

    task automatic check_outputs();
        res_t r;
        logic [N*W-1:0] rd;
        logic [N-1:0]   rv;
        r = pq.pop_front();
        for (int i = 0; i < N; i++) begin
            rd[i*W +: W] = mv[i];
            rv[i]        = mval[i];
        end
        chk("done",        done,        exp_done);
        chk("search_done", search_done, r.vld);
        chk("hit",         hit,         r.hit);
        chk("match_index", match_index, r.idx[IW-1:0]);
        chk("read_data",   read_data,   rd);
        chk("read_valid",  read_valid,  rv);
    endtask

    // One cycle: check the cycle's outputs, then drive its inputs and advance the model.
    task automatic step(input bit we, input bit ce, input int idx, input logic [W-1:0] wd,
                        input logic [W-1:0] wm, input bit wv, input bit sg,
                        input logic [W-1:0] key);
        @(negedge clk);
        check_outputs();
        write_en    = we;
        clear_en    = ce;
        index       = idx[IW-1:0];
        write_data  = wd;
        write_mask  = wm;
        write_valid = wv;
        search_go   = sg;
        search_key  = key;
        pq.push_back(model_search(sg, key));
        exp_done = we | ce;
        if (ce) begin
            for (int i = 0; i < N; i++) mval[i] = 0;
        end else if (we && idx < N) begin
            mv[idx] = wd; mm[idx] = wm; mval[idx] = wv;
        end
    endtask

    task automatic idle();
        step(0, 0, 0, '0, '0, 0, 0, '0);
    endtask

    task automatic do_reset(input int cycles);
        res_t e;
        e.vld = 0; e.hit = 0; e.idx = 0;
        @(negedge clk);
        reset      = 1'b0;
        write_en   = 1'b0;
        clear_en   = 1'b0;
        search_go  = 1'b0;
        index      = '0;
        write_data = '0;
        write_mask = '0;
        write_valid = 1'b0;
        search_key = '0;
        model_clear_all();
        for (int k = 0; k < cycles; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            check_outputs();
            pq.push_back(e);
        end
        reset = 1'b1;
    endtask

    initial begin
        model_clear_all();
        do_reset(3);

        // Single write to entry 2.
        step(1, 0, 2, 32'hA5, 32'hFF, 1, 0, '0);
        idle();
        chk("w2_done",  done,             1'b1);
        chk("w2_data",  read_data[95:64], 32'h0000_00A5);
        chk("w2_valid", read_valid,       6'h04);

        // Entries 1 and 5, then back-to-back searches.
        step(1, 0, 1, 32'h10, 32'hF0, 1, 0, '0);
        step(1, 0, 5, 32'h12, 32'hFF, 1, 0, '0);
        step(0, 0, 0, '0, '0, 0, 1, 32'h12);
        step(0, 0, 0, '0, '0, 0, 1, 32'h33);
        step(0, 0, 0, '0, '0, 0, 1, 32'h1F);
        chk("s12_done", search_done, 1'b1);
        chk("s12_hit",  hit,         1'b1);
        chk("s12_idx",  match_index, 3'd1);
        idle();
        chk("s33_done", search_done, 1'b1);
        chk("s33_hit",  hit,         1'b0);
        chk("s33_idx",  match_index, 3'd0);
        idle();
        chk("s1f_done", search_done, 1'b1);
        chk("s1f_hit",  hit,         1'b1);
        chk("s1f_idx",  match_index, 3'd1);

        // Out-of-range write: done pulses, no entry changes.
        step(1, 0, 7, 32'hDEAD, 32'h0, 1, 0, '0);
        idle();
        chk("oor_done", done, 1'b1);

        // Clear with simultaneous write and search; the search sees pre-clear contents.
        step(1, 1, 3, 32'h77, 32'hFF, 1, 1, 32'h12);
        step(0, 0, 0, '0, '0, 0, 1, 32'h12);
        chk("clr_done",  done,       1'b1);
        chk("clr_valid", read_valid, 6'h00);
        idle();
        chk("clr_srch_hit", hit,         1'b1);
        chk("clr_srch_idx", match_index, 3'd1);
        idle();
        chk("post_clr_hit", hit, 1'b0);

        // Reset one cycle after a search: the in-flight result is discarded.
        step(1, 0, 0, 32'h5, 32'h0, 1, 0, '0);
        step(0, 0, 0, '0, '0, 0, 1, 32'h5);
        do_reset(2);
        chk("rst_sd",   search_done, 1'b0);
        chk("rst_data", read_data,   {(N*W){1'b0}});
        repeat (3) idle();

        // Random traffic, narrow value/key range to get frequent hits.
        for (int c = 0; c < 3000; c++) begin
            bit we, ce, wv, sg;
            int idx;
            logic [W-1:0] wd, wm, key;
            we  = ($urandom_range(0, 2) == 0);
            ce  = ($urandom_range(0, 19) == 0);
            idx = $urandom_range(0, 7);
            wv  = ($urandom_range(0, 3) != 0);
            wd  = ($urandom & 32'hFFFF_FF00) | 32'($urandom_range(0, 15));
            wm  = ($urandom_range(0, 5) == 0) ? 32'h0 : 32'($urandom_range(0, 15));
            sg  = ($urandom_range(0, 1) == 0);
            key = ($urandom & 32'hFFFF_FF00) | 32'($urandom_range(0, 15));
            if (c % 700 == 699) begin
                do_reset(2);
            end else begin
                step(we, ce, idx, wd, wm, wv, sg, key);
            end
        end
        repeat (3) idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
